ifu_pc: RTL

Instruction-fetch unit and architectural PC register for the multicycle core. Holds the current PC, issues one instruction-memory read per instruction over a valid/ready request and response interface, and hands the fetched word to decode. When the instruction retires, it loads the next PC computed by the downstream next-PC mux. It exports `pc` and `snpc` (pc+4) to that mux and to the execute datapath.

---
 rtl/ifu_pc.sv | 115 +++++++++++
 1 files changed

// File: rtl/ifu_pc.sv
// Instruction-fetch unit: owns the architectural PC and runs one
// request/response fetch per instruction, then holds the word for decode until retirement.
module ifu_pc #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dnpc,
  input  logic        wb_valid,
  output logic [31:0] pc,
  output logic [31:0] snpc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_EXEC  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        fault_q;
  logic [31:0] cnt_q;
  logic        req_q;
  logic        ivld_q;

  // Request/decode strobes are registered alongside the state so the
  // outputs come straight from flops; reset still masks the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b1;
      ivld_q  <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_req_ready) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (imem_rsp_err) begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end else begin
              inst_q  <= imem_rsp_data;
              ivld_q  <= 1'b1;
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            cnt_q   <= cnt_q + 32'd1;
            ivld_q  <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (wb_valid) begin
            if (dnpc[1:0] == 2'b00) begin
              pc_q    <= dnpc;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end else begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end
          end
        end
        S_FAULT: begin
          req_q  <= 1'b0;
          ivld_q <= 1'b0;
        end
        default: begin
          req_q   <= 1'b0;
          ivld_q  <= 1'b0;
          state_q <= S_FAULT;
        end
      endcase
    end
  end

  assign pc             = pc_q;
  assign snpc           = pc_q + 32'd4;
  assign imem_req_valid = req_q & ~rst;
  assign imem_addr      = pc_q;
  assign inst_valid     = ivld_q;
  assign inst           = inst_q;
  assign inst_pc        = pc_q;
  assign fetch_fault    = fault_q;
  assign fetch_count    = cnt_q;

endmodule
